// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and counter/display control outputs of the stopwatch controller.
// The controller takes the slave side; the driver of the keys and enable takes the master side.
interface stopwatch_ctrl_if;
  logic       iEN;
  logic       iKEY_START;
  logic       iKEY_LAP;
  logic       oCNT_EN;
  logic       oCNT_CLR;
  logic       oLAP_LOAD;
  logic       oFREEZE;
  logic [1:0] oSTATE;

  modport master (
    output iEN, iKEY_START, iKEY_LAP,
    input  oCNT_EN, oCNT_CLR, oLAP_LOAD, oFREEZE, oSTATE
  );

  modport slave (
    input  iEN, iKEY_START, iKEY_LAP,
    output oCNT_EN, oCNT_CLR, oLAP_LOAD, oFREEZE, oSTATE
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises and debounces START/LAP, sequences counter run/clear and lap freeze.
// Optional automatic lap exit is built when SW_LAP_TIMEOUT_EN is defined.
module stopwatch_ctrl #(
  parameter int DB_CYCLES   = 500000,
  parameter int DB_W        = 19,
  parameter int LAP_TIMEOUT = 250000000
) (
  input  logic              iCLK,
  input  logic              iRST,
  stopwatch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      raw_keys;
  logic [1:0]      sync1, sync2;
  logic [1:0]      acc_lvl;
  logic [1:0]      press_q;
  logic [DB_W-1:0] db_cnt [2];
  logic            ev_start, ev_lap;
  logic            lap_timeout;
  logic            cnt_en_q, cnt_clr_q, lap_load_q, freeze_q;
  logic            cnt_clr_d, lap_load_d;

  // Bit 0 is START, bit 1 is LAP; keys are active-low so "released" is 1.
  assign raw_keys = {bus.iKEY_LAP, bus.iKEY_START};
  assign ev_start = press_q[0];
  assign ev_lap   = press_q[1];

  // A level is accepted once the synchronised key has differed from it for DB_CYCLES samples in a row;
  // a 1->0 acceptance registers a one-cycle press event.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      acc_lvl <= 2'b11;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw_keys;
      sync2   <= sync1;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == acc_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          acc_lvl[i] <= sync2[i];
          db_cnt[i]  <= '0;
          press_q[i] <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef SW_LAP_TIMEOUT_EN
  localparam int LT_W = $clog2(LAP_TIMEOUT + 1);
  logic [LT_W-1:0] lap_timer;

  // Held at zero outside LAP so it starts fresh on every entry; frozen while events are masked.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lap_timer <= '0;
    end else if (state_q != LAP) begin
      lap_timer <= '0;
    end else if (bus.iEN) begin
      lap_timer <= lap_timer + 1'b1;
    end
  end

  assign lap_timeout = (state_q == LAP) && (lap_timer == LT_W'(LAP_TIMEOUT - 1));
`else
  assign lap_timeout = 1'b0;
`endif

  // START has priority over LAP when both arrive together; key events beat the lap timeout.
  always_comb begin
    state_d    = state_q;
    cnt_clr_d  = 1'b0;
    lap_load_d = 1'b0;
    if (bus.iEN) begin
      case (state_q)
        IDLE: begin
          if (ev_start)    state_d = RUN;
          else if (ev_lap) cnt_clr_d = 1'b1;
        end
        RUN: begin
          if (ev_start) begin
            state_d = PAUSE;
          end else if (ev_lap) begin
            state_d    = LAP;
            lap_load_d = 1'b1;
          end
        end
        LAP: begin
          if (ev_start)         state_d = PAUSE;
          else if (ev_lap)      state_d = RUN;
          else if (lap_timeout) state_d = RUN;
        end
        PAUSE: begin
          if (ev_start) begin
            state_d = RUN;
          end else if (ev_lap) begin
            state_d   = IDLE;
            cnt_clr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= IDLE;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b1;
      lap_load_q <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_en_q   <= (state_d == RUN) || (state_d == LAP);
      cnt_clr_q  <= cnt_clr_d;
      lap_load_q <= lap_load_d;
      freeze_q   <= (state_d == LAP);
    end
  end

  assign bus.oCNT_EN   = cnt_en_q;
  assign bus.oCNT_CLR  = cnt_clr_q;
  assign bus.oLAP_LOAD = lap_load_q;
  assign bus.oFREEZE   = freeze_q;
  assign bus.oSTATE    = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the stopwatch counter chain and the display path.
- Synchronises and debounces the START and LAP pushbuttons, then turns each press into a one-cycle event.
- Drives the run enable for the first counter stage, a synchronous clear for the whole chain, and the lap-freeze controls for the display latch that feeds the segment decoders.
- Replaces the toggle-flop start logic in the stopwatch top level.

Parameters:
- DB_CYCLES, 500000: consecutive stable cycles a synchronised key level must hold before it is accepted (10 ms at 50 MHz).
- DB_W, 19: width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.
- LAP_TIMEOUT, 250000000: cycles before an automatic LAP exit. Used only with SW_LAP_TIMEOUT_EN.

Ports:
- iCLK  input  1  system clock, 50 MHz
- iRST  input  1  synchronous reset, active-high
- iEN  input  1  mode enable (board switch); low masks all key events
- iKEY_START  input  1  raw START pushbutton, active-low, asynchronous
- iKEY_LAP  input  1  raw LAP/RESET pushbutton, active-low, asynchronous
- oCNT_EN  output  1  run enable to the first counter stage (the 1 ms prescaler)
- oCNT_CLR  output  1  synchronous clear to all counter stages
- oLAP_LOAD  output  1  one-cycle strobe: display latch captures the live counter digits
- oFREEZE  output  1  1 = display shows latched digits; 0 = display shows live digits
- oSTATE  output  2  current state: IDLE=0, RUN=1, PAUSE=2, LAP=3

Behaviour:
- Clocking and reset: all flops are on iCLK rising edge. iRST is synchronous, active-high.
- Reset values: state IDLE, oCNT_EN 0, oCNT_CLR 1, oLAP_LOAD 0, oFREEZE 0, oSTATE 0, debounced levels 1 (released), debounce counters 0.
- oCNT_CLR stays high while iRST is high and drops in the first cycle after iRST falls.
- Synchroniser: each key passes through a 2-flop synchroniser.
- Debounce:
  - Per-key counter clears whenever the synchronised level equals the accepted level.
  - Otherwise the counter increments.
  - When it reaches DB_CYCLES-1, the accepted level takes the synchronised level and the counter clears.
  - Any bounce back to the accepted level restarts the count.
- Press event: accepted level goes 1->0, giving a one-cycle pulse. Release generates nothing.
- Event masking: when iEN=0, events are discarded. Debouncers keep running, and state and outputs are held.
- Latency: raw key edge to event is 2 + DB_CYCLES cycles. Event to registered outputs is 1 cycle.
- Simultaneous START and LAP events in one cycle: START wins and LAP is dropped.
- FSM transitions (outputs registered and updated on the transition edge):
  - IDLE + START -> RUN.
  - IDLE + LAP -> IDLE, with a oCNT_CLR 1-cycle pulse.
  - RUN + START -> PAUSE.
  - RUN + LAP -> LAP, with a oLAP_LOAD 1-cycle pulse; oFREEZE rises in the same cycle as oLAP_LOAD.
  - LAP + LAP -> RUN; oFREEZE falls.
  - LAP + START -> PAUSE; oFREEZE falls, so the paused live value is shown.
  - PAUSE + START -> RUN.
  - PAUSE + LAP -> IDLE, with a oCNT_CLR 1-cycle pulse.
- Output decode:
  - oCNT_EN = 1 exactly in RUN and LAP.
  - oFREEZE = 1 exactly in LAP.
  - oLAP_LOAD and oCNT_CLR (outside reset) are never high for more than 1 cycle.
- Reset mid-operation: iRST in any state forces the reset values next cycle. Partially debounced presses are lost.
- Keys held down: produce exactly one event; no auto-repeat.

Optional Feature:
- SW_LAP_TIMEOUT_EN defined:
  - A lap timer of width $clog2(LAP_TIMEOUT+1) clears on entry to LAP and increments each cycle in LAP.
  - On reaching LAP_TIMEOUT-1 with no event, the FSM goes LAP -> RUN and oFREEZE falls.
  - An event in the same cycle as the timeout takes priority over the timeout.
- SW_LAP_TIMEOUT_EN undefined: no lap timer; LAP persists until a key event; LAP_TIMEOUT is ignored.

Test Plan:
- Reset behaviour (DB_CYCLES=4 for all tests): hold iRST 3 cycles, then release -> oCNT_CLR high through reset and low 1 cycle after release; all other outputs 0; oSTATE=0.
- Start/stop:
  - START press with 3 cycles of bounce, then stable low -> exactly one event; oCNT_EN rises 2+4+1 cycles after the last bounce edge; oSTATE=1.
  - Second press -> oCNT_EN=0, oSTATE=2.
- Lap sequence: in RUN, press LAP -> oLAP_LOAD high 1 cycle coincident with oFREEZE rising, oCNT_EN stays 1, oSTATE=3; LAP again -> oFREEZE 0, oSTATE=1.
- Clear from pause: RUN -> START -> PAUSE -> LAP -> oCNT_CLR 1-cycle pulse, oSTATE=0; START then returns to RUN.
- Masking and priority:
  - iEN=0 while pressing START -> no state change.
  - With iEN=1, START and LAP debounce-accepted in the same cycle from RUN -> PAUSE, no oLAP_LOAD.
- Timeout (SW_LAP_TIMEOUT_EN, LAP_TIMEOUT=20): enter LAP, no keys -> after 20 cycles oSTATE=1, oFREEZE=0. With the macro undefined -> still LAP after 100 cycles.
